sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
Two-client arbiter sitting directly upstream of the sdram controller user port (addr/rw/data_in/in_valid/busy/data_out/out_valid).
- Lets the ram test engine share the memory with a second client (e.g. a debug/UART loader).
- Serialises commands through a one-entry command register.
- Tracks issuing client of every outstanding read in an in-order tag FIFO; routes read data back to the issuing client.

Parameters:
ADDR_W, 25, address width (matches controller addr)
DATA_W, 32, data width (matches controller data_in/data_out)
TAG_DEPTH, 8, max outstanding reads; power of two, >=2

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low (reset when rst==0 at posedge clk)
c0_addr  in  ADDR_W  client 0 address
c0_rw  in  1  client 0 direction: 1=write, 0=read
c0_wdata  in  DATA_W  client 0 write data
c0_valid  in  1  client 0 request
c0_ready  out  1  client 0 accept; transfer when c0_valid&c0_ready
c0_rdata  out  DATA_W  client 0 read data
c0_rvalid  out  1  client 0 read data strobe, 1 cycle
c1_addr, c1_rw, c1_wdata, c1_valid, c1_ready, c1_rdata, c1_rvalid: same as client 0, for client 1
mem_addr  out  ADDR_W  to controller addr
mem_rw  out  1  to controller rw
mem_data_in  out  DATA_W  to controller data_in
mem_in_valid  out  1  to controller in_valid
mem_busy  in  1  from controller busy
mem_data_out  in  DATA_W  from controller data_out
mem_out_valid  in  1  from controller out_valid
err  out  1  sticky: read data returned with no tag outstanding

Behaviour:
- Reset (rst==0): all outputs 0; state IDLE; tag FIFO empty; last_grant=1 (client 0 wins first); err=0. Reset mid-operation drops held command and all tags.
- Controller handshake: command accepted on a cycle with mem_in_valid=1 and mem_busy=0. Read data returns in order, one mem_out_valid pulse per read.
- State IDLE:
  - Eligible client: valid=1 and (rw=1 or tag FIFO not full).
  - Round-robin: with both eligible, grant the one != last_grant.
  - Granted client's ready asserted combinationally this cycle; other ready=0.
  - On grant: latch addr/rw/wdata into mem_* and client id; update last_grant; set mem_in_valid=1 next cycle; go ISSUE.
  - No eligible client: stay IDLE, mem_in_valid=0.
- State ISSUE:
  - mem_in_valid=1; mem_addr/mem_rw/mem_data_in held stable; both ready=0.
  - If mem_busy==0: command accepted; if read, push client id into tag FIFO; mem_in_valid=0 next cycle; go IDLE.
  - If mem_busy==1: hold indefinitely.
  - Throughput: at most 1 command per 2 cycles.
- Latency:
  - Client accept at cycle N -> mem_in_valid=1 at N+1.
  - mem_out_valid at cycle M -> pop tag, register mem_data_out into cX_rdata; cX_rvalid=1 at M+1 for exactly 1 cycle.
  - cX_rdata holds last value until the next return for that client.
- Tag FIFO:
  - Push and pop in the same cycle are legal; count unchanged.
  - Full (TAG_DEPTH entries): reads are ineligible; writes still granted.
  - Pointers wrap modulo TAG_DEPTH.
- mem_out_valid with tag FIFO empty: data discarded, no rvalid, err=1 until reset.
- Client-side rule: fields stable while valid=1 and ready=0; arbiter never drops an accepted request.

Optional Feature:
Macro SDRAM_ARB_FIXED_PRIO_EN.
- Defined: client 0 always wins when both eligible (client 1 can starve); last_grant unused.
- Undefined: round-robin as above.

Test Plan:
- Reset then c0 write addr=0x0000010 data=0xDEADBEEF, mem_busy=0 -> c0_ready at cycle N; mem_in_valid=1, mem_addr=0x0000010, mem_rw=1, mem_data_in=0xDEADBEEF at N+1 only; tag FIFO count stays 0.
- c0 and c1 reads valid together continuously, mem_busy=0 -> grants alternate c0,c1,c0,c1 (c0 first); controller model returns 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> c0_rvalid with 0x11111111, c1_rvalid with 0x22222222, c0 0x33333333, c1 0x44444444, each 1 cycle after mem_out_valid.
- mem_busy=1 for 5 cycles during ISSUE -> mem_in_valid and mem_addr held 5 cycles, both ready=0; accepted on cycle mem_busy=0.
- 8 reads issued with no returns -> 9th read not granted (c0_ready=0) while c1 write is granted; one mem_out_valid -> 9th read granted next IDLE.
- mem_out_valid with no outstanding read -> err=1, no rvalid; stays 1 until rst=0 clears it.
- rst=0 asserted during ISSUE with 3 reads outstanding -> next cycle mem_in_valid=0, err=0, tag FIFO empty, first grant after reset goes to c0.

Source files
------------

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-client round-robin arbiter in front of the sdram controller user port.
// Latency: client accept at N -> mem_in_valid at N+1; mem_out_valid at M -> cX_rvalid at M+1.
// Backpressure: mem_busy holds the command register; reads are held off while the tag FIFO is full.
// Ports: clk/rst (sync, active-low); c0_*/c1_* client request + read-return ports;
//        mem_* controller user port; err sticky flag for read data with no tag outstanding.
// Optional: define SDRAM_ARB_FIXED_PRIO_EN for fixed priority (client 0 always wins).
module sdram_arbiter #(
  parameter int ADDR_W    = 25,
  parameter int DATA_W    = 32,
  parameter int TAG_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic              c0_rw,
  input  logic [DATA_W-1:0] c0_wdata,
  input  logic              c0_valid,
  output logic              c0_ready,
  output logic [DATA_W-1:0] c0_rdata,
  output logic              c0_rvalid,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic              c1_rw,
  input  logic [DATA_W-1:0] c1_wdata,
  input  logic              c1_valid,
  output logic              c1_ready,
  output logic [DATA_W-1:0] c1_rdata,
  output logic              c1_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rw,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_in_valid,
  input  logic              mem_busy,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_out_valid,
  output logic              err
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam logic [PTR_W:0] TAG_FULL_CNT = (PTR_W+1)'(TAG_DEPTH);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  logic [0:0]       state;
  logic             last_grant;   // id of the most recently granted client
  logic             cmd_id;       // id of the client owning the held command
  logic             tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   tag_cnt;

  logic tag_full, tag_empty;
  logic c0_elig, c1_elig;
  logic gnt0, gnt1;
  logic push, pop;

  assign tag_full  = (tag_cnt == TAG_FULL_CNT);
  assign tag_empty = (tag_cnt == '0);

  // Writes never create a tag, so they stay eligible while the FIFO is full.
  assign c0_elig = c0_valid & (c0_rw | ~tag_full);
  assign c1_elig = c1_valid & (c1_rw | ~tag_full);

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  assign gnt0 = c0_elig;
  assign gnt1 = c1_elig & ~c0_elig;
`else
  // Contention goes to the client that did not win last time.
  assign gnt0 = c0_elig & (~c1_elig | last_grant);
  assign gnt1 = c1_elig & (~c0_elig | ~last_grant);
`endif

  // Gated by rst so nothing is handed out while reset is being sampled.
  assign c0_ready = rst & (state == ST_IDLE) & gnt0;
  assign c1_ready = rst & (state == ST_IDLE) & gnt1;

  // A read is tagged at the moment the controller accepts it.
  assign push = (state == ST_ISSUE) & ~mem_busy & ~mem_rw;
  assign pop  = mem_out_valid & ~tag_empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      last_grant   <= 1'b1;
      cmd_id       <= 1'b0;
      mem_addr     <= '0;
      mem_rw       <= 1'b0;
      mem_data_in  <= '0;
      mem_in_valid <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      tag_cnt      <= '0;
      c0_rdata     <= '0;
      c0_rvalid    <= 1'b0;
      c1_rdata     <= '0;
      c1_rvalid    <= 1'b0;
      err          <= 1'b0;
    end else begin
      c0_rvalid <= 1'b0;
      c1_rvalid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (gnt0 | gnt1) begin
            mem_addr     <= gnt1 ? c1_addr  : c0_addr;
            mem_rw       <= gnt1 ? c1_rw    : c0_rw;
            mem_data_in  <= gnt1 ? c1_wdata : c0_wdata;
            cmd_id       <= gnt1;
            last_grant   <= gnt1;
            mem_in_valid <= 1'b1;
            state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!mem_busy) begin
            mem_in_valid <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (push) wr_ptr <= wr_ptr + 1'b1;

      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (tag_mem[rd_ptr]) begin
          c1_rdata  <= mem_data_out;
          c1_rvalid <= 1'b1;
        end else begin
          c0_rdata  <= mem_data_out;
          c0_rvalid <= 1'b1;
        end
      end else if (mem_out_valid) begin
        // Return with nothing outstanding: drop the data, flag it.
        err <= 1'b1;
      end

      case ({push, pop})
        2'b10:   tag_cnt <= tag_cnt + 1'b1;
        2'b01:   tag_cnt <= tag_cnt - 1'b1;
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end

  // Tag storage needs no reset; validity is carried by the pointers/count.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= cmd_id;
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
module tb_sdram_arbiter;

  logic        clk;
  logic        rst;
  logic [24:0] c0_addr, c1_addr;
  logic        c0_rw, c1_rw;
  logic [31:0] c0_wdata, c1_wdata;
  logic        c0_valid, c1_valid;
  logic        c0_ready, c1_ready;
  logic [31:0] c0_rdata, c1_rdata;
  logic        c0_rvalid, c1_rvalid;
  logic [24:0] mem_addr;
  logic        mem_rw;
  logic [31:0] mem_data_in;
  logic        mem_in_valid;
  logic        mem_busy;
  logic [31:0] mem_data_out;
  logic        mem_out_valid;
  logic        err;

  int total = 0;
  int bad   = 0;

  sdram_arbiter dut (
    .clk(clk), .rst(rst),
    .c0_addr(c0_addr), .c0_rw(c0_rw), .c0_wdata(c0_wdata), .c0_valid(c0_valid),
    .c0_ready(c0_ready), .c0_rdata(c0_rdata), .c0_rvalid(c0_rvalid),
    .c1_addr(c1_addr), .c1_rw(c1_rw), .c1_wdata(c1_wdata), .c1_valid(c1_valid),
    .c1_ready(c1_ready), .c1_rdata(c1_rdata), .c1_rvalid(c1_rvalid),
    .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_data_in(mem_data_in),
    .mem_in_valid(mem_in_valid), .mem_busy(mem_busy),
    .mem_data_out(mem_data_out), .mem_out_valid(mem_out_valid),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [31:0] rd [4];

  initial begin
    rd[0] = 32'h11111111; rd[1] = 32'h22222222;
    rd[2] = 32'h33333333; rd[3] = 32'h44444444;

    rst = 1'b0;
    c0_addr = '0; c0_rw = 1'b0; c0_wdata = '0; c0_valid = 1'b0;
    c1_addr = '0; c1_rw = 1'b0; c1_wdata = '0; c1_valid = 1'b0;
    mem_busy = 1'b0; mem_data_out = '0; mem_out_valid = 1'b0;

    // Reset state; a request during reset must not be granted
    tick(); tick();
    chk("rst_in_valid", mem_in_valid, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_err", err, 0);
    chk("rst_c0_rvalid", c0_rvalid, 0);
    chk("rst_c1_rvalid", c1_rvalid, 0);
    c0_valid = 1'b1; c0_rw = 1'b1;
    #1;
    chk("rst_c0_ready", c0_ready, 0);
    tick();
    chk("rst_no_issue", mem_in_valid, 0);
    c0_valid = 1'b0;
    rst = 1'b1;

    // Single client-0 write
    c0_valid = 1'b1; c0_rw = 1'b1; c0_addr = 25'h0000010; c0_wdata = 32'hDEADBEEF;
    #1;
    chk("wr_c0_ready", c0_ready, 1);
    chk("wr_c1_ready", c1_ready, 0);
    chk("wr_pre_in_valid", mem_in_valid, 0);
    tick();
    c0_valid = 1'b0;
    #1;
    chk("wr_in_valid", mem_in_valid, 1);
    chk("wr_addr", mem_addr, 25'h0000010);
    chk("wr_rw", mem_rw, 1);
    chk("wr_data", mem_data_in, 32'hDEADBEEF);
    chk("wr_issue_ready", c0_ready, 0);
    tick();
    chk("wr_in_valid_drop", mem_in_valid, 0);

    // Client-1 write alone
    c1_valid = 1'b1; c1_rw = 1'b1; c1_addr = 25'h0000020; c1_wdata = 32'h12345678;
    #1;
    chk("c1wr_ready", c1_ready, 1);
    chk("c1wr_c0_ready", c0_ready, 0);
    tick();
    c1_valid = 1'b0;
    chk("c1wr_addr", mem_addr, 25'h0000020);
    chk("c1wr_data", mem_data_in, 32'h12345678);
    tick();

    // Contending reads alternate c0, c1, c0, c1
    c0_valid = 1'b1; c0_rw = 1'b0; c0_addr = 25'h0000100;
    c1_valid = 1'b1; c1_rw = 1'b0; c1_addr = 25'h0000200;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_c0_ready", c0_ready, (i % 2 == 0));
      chk("rr_c1_ready", c1_ready, (i % 2 == 1));
      tick();
      chk("rr_in_valid", mem_in_valid, 1);
      chk("rr_rw", mem_rw, 0);
      chk("rr_addr", mem_addr, (i % 2 == 0) ? 25'h0000100 : 25'h0000200);
      tick();
    end
    c0_valid = 1'b0; c1_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_data_out = rd[k]; mem_out_valid = 1'b1;
      tick();
      mem_out_valid = 1'b0;
      chk("ret_c0_rvalid", c0_rvalid, (k % 2 == 0));
      chk("ret_c1_rvalid", c1_rvalid, (k % 2 == 1));
      chk("ret_rdata", (k % 2 == 0) ? c0_rdata : c1_rdata, rd[k]);
      tick();
      chk("ret_pulse_c0", c0_rvalid, 0);
      chk("ret_pulse_c1", c1_rvalid, 0);
    end

    // Controller busy holds the command for 5 cycles
    c0_valid = 1'b1; c0_rw = 1'b1; c0_addr = 25'h0000333; c0_wdata = 32'hCAFE0003;
    #1;
    chk("busy_c0_ready", c0_ready, 1);
    tick();
    c0_valid = 1'b0; mem_busy = 1'b1;
    c1_valid = 1'b1; c1_rw = 1'b1; c1_addr = 25'h0000444; c1_wdata = 32'h00000044;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("busy_in_valid", mem_in_valid, 1);
      chk("busy_addr", mem_addr, 25'h0000333);
      chk("busy_c0_hold", c0_ready, 0);
      chk("busy_c1_hold", c1_ready, 0);
      tick();
    end
    mem_busy = 1'b0;
    #1;
    chk("busy_release_in_valid", mem_in_valid, 1);
    tick();
    chk("busy_accepted", mem_in_valid, 0);
    chk("busy_then_c1_ready", c1_ready, 1);
    tick();
    c1_valid = 1'b0;
    chk("busy_c1_addr", mem_addr, 25'h0000444);
    tick();

    // Fill the tag FIFO with 8 reads
    c0_valid = 1'b1; c0_rw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      c0_addr = 25'h0000500 + 25'(i);
      #1;
      chk("fill_c0_ready", c0_ready, 1);
      tick();
      tick();
    end
    c0_addr = 25'h0000600;
    c1_valid = 1'b1; c1_rw = 1'b1; c1_addr = 25'h0000700; c1_wdata = 32'h00000077;
    #1;
    chk("full_c0_blocked", c0_ready, 0);
    chk("full_c1_write_ok", c1_ready, 1);
    tick();
    c1_valid = 1'b0;
    chk("full_c1_addr", mem_addr, 25'h0000700);
    tick();
    chk("full_still_blocked", c0_ready, 0);
    mem_data_out = 32'hAAAA0001; mem_out_valid = 1'b1;
    tick();
    mem_out_valid = 1'b0;
    chk("full_pop_rvalid", c0_rvalid, 1);
    chk("full_pop_rdata", c0_rdata, 32'hAAAA0001);
    chk("full_unblocked", c0_ready, 1);
    tick();
    chk("ninth_addr", mem_addr, 25'h0000600);
    chk("ninth_rw", mem_rw, 0);
    chk("ninth_in_valid", mem_in_valid, 1);
    c0_valid = 1'b0;
    tick();
    mem_out_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mem_data_out = 32'h000000B0 + 32'(i);
      tick();
      chk("drain_rvalid", c0_rvalid, 1);
      chk("drain_rdata", c0_rdata, 32'h000000B0 + 32'(i));
    end
    mem_out_valid = 1'b0;
    tick();
    chk("drain_rvalid_end", c0_rvalid, 0);
    chk("drain_err", err, 0);

    // Return with nothing outstanding
    mem_data_out = 32'h00000BAD; mem_out_valid = 1'b1;
    tick();
    mem_out_valid = 1'b0;
    chk("orphan_err", err, 1);
    chk("orphan_c0_rvalid", c0_rvalid, 0);
    chk("orphan_c1_rvalid", c1_rvalid, 0);
    chk("orphan_rdata_kept", c0_rdata, 32'h000000B7);
    tick(); tick();
    chk("orphan_err_sticky", err, 1);

    // Reset during ISSUE with 3 reads outstanding
    c1_valid = 1'b1; c1_rw = 1'b0; c1_addr = 25'h0000800;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("pre_c1_ready", c1_ready, 1);
      tick();
      tick();
    end
    c1_valid = 1'b0;
    c0_valid = 1'b1; c0_rw = 1'b0; c0_addr = 25'h0000900;
    #1;
    chk("pre_c0_ready", c0_ready, 1);
    tick();
    c0_valid = 1'b0; mem_busy = 1'b1;
    chk("pre_issue", mem_in_valid, 1);
    tick();
    rst = 1'b0;
    tick();
    chk("mid_rst_in_valid", mem_in_valid, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_addr", mem_addr, 0);
    rst = 1'b1; mem_busy = 1'b0;
    mem_data_out = 32'h00000055; mem_out_valid = 1'b1;
    tick();
    mem_out_valid = 1'b0;
    chk("post_rst_tags_empty_err", err, 1);
    chk("post_rst_c1_rvalid", c1_rvalid, 0);
    chk("post_rst_c0_rvalid", c0_rvalid, 0);
    c0_valid = 1'b1; c0_rw = 1'b0; c0_addr = 25'h0000A00;
    c1_valid = 1'b1; c1_rw = 1'b0; c1_addr = 25'h0000B00;
    #1;
    chk("post_rst_c0_first", c0_ready, 1);
    chk("post_rst_c1_wait", c1_ready, 0);
    tick();
    c0_valid = 1'b0; c1_valid = 1'b0;
    chk("post_rst_addr", mem_addr, 25'h0000A00);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
